// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared state encoding and sizing for the FIFO read controller
package fifo_rd_pkg;
    typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;
    localparam int BUF_DEPTH = 3;
    localparam int OCC_W = 2;
    localparam int CNT_W = 16;
endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: 3-entry in-order buffer, head always at entry 0
module fifo_rd_skid import fifo_rd_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] head,
    output logic [OCC_W-1:0] occ
);
    logic [BUF_DEPTH-1:0][WIDTH-1:0] mem, mem_nxt;
    logic [OCC_W-1:0] wr_idx;
    assign wr_idx = occ - OCC_W'(pop);
    assign head = mem[0];
    // shift toward the head on pop, then place the pushed word behind the survivors
    always_comb begin
        mem_nxt = pop ? mem >> WIDTH : mem;
        if (push) mem_nxt[wr_idx] = data;
    end
    // clear empties the buffer and zeroes the head so stale data never shows
    always_ff @(posedge clk_i) begin
        if (clear) begin
            mem <= '0;
            occ <= '0;
        end else begin
            mem <= mem_nxt;
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: turns a synchronous FIFO into a valid/ready stream; FIFO_RD_CNT_EN adds a transfer counter
module fifo_rd_ctrl import fifo_rd_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    output logic             fifo_rd_en_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    input  logic             flush_i,
    output logic             drop_o
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [CNT_W-1:0] count_o
`endif
);
    state_t state, state_nxt;
    logic infl, push, pop;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0] pend, pend_nxt;
    assign pend = {1'b0, occ} + (OCC_W+1)'(infl);
    assign pend_nxt = {1'b0, occ} + (OCC_W+1)'(push) - (OCC_W+1)'(pop) + (OCC_W+1)'(fifo_rd_en_o);
    assign fifo_rd_en_o = rst_i && state != FLUSH && !fifo_empty_i && pend < (OCC_W+1)'(BUF_DEPTH);
    assign m_valid_o = rst_i && state != FLUSH && occ != '0;
    assign push = infl && state != FLUSH && !flush_i;
    assign pop = m_valid_o && m_ready_i && !flush_i;
    fifo_rd_skid #(.WIDTH(WIDTH)) u_skid (
        .clk_i(clk_i),
        .push (push),
        .pop  (pop),
        .clear(!rst_i || flush_i),
        .data (fifo_rdata_i),
        .head (m_data_o),
        .occ  (occ)
    );
    // flush wins; FLUSH waits out the in-flight word; otherwise track whether anything is pending
    always_comb begin
        state_nxt = state;
        if (flush_i) state_nxt = FLUSH;
        else if (state == FLUSH) state_nxt = infl ? FLUSH : IDLE;
        else state_nxt = pend_nxt != '0 ? ACTIVE : IDLE;
    end
    // state, in-flight flag and drop pulse
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state <= IDLE;
            infl <= 1'b0;
            drop_o <= 1'b0;
        end else begin
            state <= state_nxt;
            infl <= fifo_rd_en_o;
            drop_o <= flush_i && pend != '0;
        end
    end
`ifdef FIFO_RD_CNT_EN
    // transfer counter, wraps naturally and ignores flush
    always_ff @(posedge clk_i) begin
        if (!rst_i) count_o <= '0;
        else if (pop) count_o <= count_o + 1'b1;
    end
`endif
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: randomized and directed bench against a queue-based reference model
module tb_fifo_rd_ctrl;
    localparam int W = 8;
    logic clk_i = 1'b0;
    logic rst_i = 1'b0, fifo_empty_i = 1'b1, m_ready_i = 1'b0, flush_i = 1'b0;
    logic [W-1:0] fifo_rdata_i = '0;
    logic fifo_rd_en_o, m_valid_o, drop_o;
    logic [W-1:0] m_data_o;
`ifdef FIFO_RD_CNT_EN
    logic [15:0] count_o;
`endif
    int n_tests = 0, n_fail = 0;
    logic [W-1:0] src[$], mq[$], got[$];
    logic [W-1:0] nxt_rdata = '0;
    bit m_infl = 0, m_flushing = 0, m_drop = 0, feed = 0;
    int unsigned m_cnt = 0;
    int cyc = 0, first_x = 0, last_x = 0, rd_cnt = 0, drop_cnt = 0;

    always #5 clk_i = ~clk_i;

    fifo_rd_ctrl #(.WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_rdata_i(fifo_rdata_i),
        .fifo_rd_en_o(fifo_rd_en_o),
        .m_data_o    (m_data_o),
        .m_valid_o   (m_valid_o),
        .m_ready_i   (m_ready_i),
        .flush_i     (flush_i),
        .drop_o      (drop_o)
`ifdef FIFO_RD_CNT_EN
        ,
        .count_o     (count_o)
`endif
    );

    task automatic cycle(input bit rdy, input bit fl, input bit rs);
        bit e_rd, e_val, dut_rd;
        if (feed && src.size() < 4) src.push_back(W'($urandom));
        m_ready_i = rdy; flush_i = fl; rst_i = rs;
        fifo_empty_i = (src.size() == 0);
        fifo_rdata_i = nxt_rdata;
        e_rd = rs && !m_flushing && src.size() != 0 && (mq.size() + int'(m_infl)) < 3;
        e_val = rs && !m_flushing && mq.size() != 0;
        #1;
        n_tests++;
        if (fifo_rd_en_o !== e_rd) begin n_fail++; $display("FAIL rd_en cyc %0d: got %b exp %b", cyc, fifo_rd_en_o, e_rd); end
        n_tests++;
        if (m_valid_o !== e_val) begin n_fail++; $display("FAIL valid cyc %0d: got %b exp %b", cyc, m_valid_o, e_val); end
        n_tests++;
        if (drop_o !== m_drop) begin n_fail++; $display("FAIL drop cyc %0d: got %b exp %b", cyc, drop_o, m_drop); end
        if (e_val) begin
            n_tests++;
            if (m_data_o !== mq[0]) begin n_fail++; $display("FAIL data cyc %0d: got %h exp %h", cyc, m_data_o, mq[0]); end
        end
`ifdef FIFO_RD_CNT_EN
        n_tests++;
        if (count_o !== 16'(m_cnt)) begin n_fail++; $display("FAIL count cyc %0d: got %h exp %h", cyc, count_o, 16'(m_cnt)); end
`endif
        dut_rd = fifo_rd_en_o;
        if (m_valid_o && rdy && !fl && rs) begin
            if (got.size() == 0) first_x = cyc;
            last_x = cyc;
            got.push_back(m_data_o);
        end
        rd_cnt += int'(dut_rd);
        drop_cnt += int'(drop_o);
        @(posedge clk_i);
        nxt_rdata = W'($urandom);
        if (dut_rd && src.size() != 0) nxt_rdata = src.pop_front();
        if (!rs) begin
            mq.delete(); m_infl = 0; m_flushing = 0; m_drop = 0; m_cnt = 0;
        end else if (fl) begin
            m_drop = (mq.size() + int'(m_infl)) > 0;
            mq.delete(); m_flushing = 1; m_infl = e_rd;
        end else begin
            m_drop = 0;
            if (e_val && rdy) begin void'(mq.pop_front()); m_cnt = (m_cnt + 1) & 32'hFFFF; end
            if (m_infl && !m_flushing) mq.push_back(fifo_rdata_i);
            if (m_flushing && !m_infl) m_flushing = 0;
            m_infl = e_rd;
        end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic start(input int nwords, output logic [W-1:0] w[$]);
        src.delete(); w.delete();
        repeat (2) cycle(0, 0, 0);
        for (int i = 0; i < nwords; i++) w.push_back(W'($urandom));
        src = w;
        got.delete(); rd_cnt = 0; drop_cnt = 0;
    endtask

    task automatic test_reset();
        logic [W-1:0] w[$];
        start(0, w);
        n_tests++;
        if (m_data_o !== '0) begin n_fail++; $display("FAIL reset_data: got %h exp 00", m_data_o); end
        cycle(1, 0, 1);
    endtask

    task automatic test_latency();
        logic [W-1:0] w[$];
        logic [W-1:0] exp_w[$];
        int base;
        start(0, w);
        exp_w = '{8'h11, 8'h22, 8'h33};
        src = exp_w;
        base = cyc;
        repeat (8) cycle(1, 0, 1);
        n_tests++;
        if (got != exp_w) begin n_fail++; $display("FAIL latency_order: got %p exp %p", got, exp_w); end
        n_tests++;
        if (first_x - base != 2 || last_x - base != 4) begin
            n_fail++; $display("FAIL latency_cycles: got %0d..%0d exp 2..4", first_x - base, last_x - base);
        end
        n_tests++;
        if (rd_cnt != 3) begin n_fail++; $display("FAIL latency_reads: got %0d exp 3", rd_cnt); end
    endtask

    task automatic test_stall();
        logic [W-1:0] w[$];
        start(5, w);
        repeat (8) cycle(0, 0, 1);
        n_tests++;
        if (rd_cnt != 3) begin n_fail++; $display("FAIL stall_reads: got %0d exp 3", rd_cnt); end
        repeat (12) cycle(1, 0, 1);
        n_tests++;
        if (got != w) begin n_fail++; $display("FAIL stall_order: got %p exp %p", got, w); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w[$];
        start(20, w);
        repeat (25) cycle(1, 0, 1);
        n_tests++;
        if (got != w) begin n_fail++; $display("FAIL b2b_order: got %0d words", got.size()); end
        n_tests++;
        if (last_x - first_x != 19) begin n_fail++; $display("FAIL b2b_rate: span %0d exp 19", last_x - first_x); end
`ifdef FIFO_RD_CNT_EN
        n_tests++;
        if (count_o !== 16'd20) begin n_fail++; $display("FAIL b2b_count: got %0d exp 20", count_o); end
`endif
    endtask

    task automatic test_flush();
        logic [W-1:0] w[$];
        start(6, w);
        repeat (3) cycle(0, 0, 1);
        drop_cnt = 0;
        cycle(0, 1, 1);
        repeat (4) cycle(0, 0, 1);
        n_tests++;
        if (drop_cnt != 1) begin n_fail++; $display("FAIL flush_drop: got %0d pulses exp 1", drop_cnt); end
        repeat (6) cycle(1, 0, 1);
        n_tests++;
        if (got.size() != 3 || got[0] !== w[3] || got[1] !== w[4] || got[2] !== w[5]) begin
            n_fail++; $display("FAIL flush_after: got %p exp %h %h %h", got, w[3], w[4], w[5]);
        end
    endtask

    task automatic test_midreset();
        logic [W-1:0] w[$];
        start(6, w);
        repeat (3) cycle(0, 0, 1);
        cycle(0, 0, 0);
        #0;
        n_tests++;
        if (m_valid_o !== 1'b0 || fifo_rd_en_o !== 1'b0 || m_data_o !== '0) begin
            n_fail++; $display("FAIL midreset: got v=%b rd=%b d=%h exp 0 0 00", m_valid_o, fifo_rd_en_o, m_data_o);
        end
        cycle(0, 0, 0);
        repeat (8) cycle(1, 0, 1);
        n_tests++;
        if (got.size() != 3 || got[0] !== w[3] || got[2] !== w[5]) begin
            n_fail++; $display("FAIL midreset_after: got %p exp %h %h %h", got, w[3], w[4], w[5]);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] w[$];
        start(0, w);
        for (int i = 0; i < 400; i++) begin
            if ($urandom % 3 != 0) src.push_back(W'($urandom));
            cycle($urandom % 4 != 0, $urandom % 25 == 0, $urandom % 60 != 0);
        end
    endtask

`ifdef FIFO_RD_CNT_EN
    task automatic test_count_wrap();
        logic [W-1:0] w[$];
        int guard;
        start(0, w);
        feed = 1;
        guard = 0;
        while (m_cnt != 32'hFFFF && guard < 70000) begin cycle(1, 0, 1); guard++; end
        n_tests++;
        if (count_o !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_max: got %h exp ffff", count_o); end
        cycle(1, 0, 1);
        n_tests++;
        if (count_o !== 16'h0000) begin n_fail++; $display("FAIL wrap_zero: got %h exp 0000", count_o); end
        feed = 0;
    endtask
`endif

    initial begin
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        test_reset();
        test_latency();
        test_stall();
        test_back_to_back();
        test_flush();
        test_midreset();
        test_random();
`ifdef FIFO_RD_CNT_EN
        test_count_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, data width in bits.
REQ-002 Port: clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst_i  input  1  reset, synchronous, active-low.
REQ-004 Port: fifo_empty_i  input  1  empty flag of the upstream synchronous FIFO.
REQ-005 Port: fifo_rdata_i  input  WIDTH  FIFO read data, valid the cycle after a read is issued.
REQ-006 Port: fifo_rd_en_o  output  1  FIFO read strobe.
REQ-007 Port: m_data_o  output  WIDTH  stream data, head of internal buffer.
REQ-008 Port: m_valid_o  output  1  stream valid.
REQ-009 Port: m_ready_i  input  1  stream ready from downstream.
REQ-010 Port: flush_i  input  1  discard all buffered and in-flight words.
REQ-011 Port: drop_o  output  1  one-cycle pulse per flush that discarded at least one word.

Function
REQ-012 The block SHALL contain a 3-entry in-order buffer (occ 0..3) plus an in-flight flag (infl 0/1).
REQ-013 fifo_rd_en_o SHALL be 1 iff rst_i=1, state=ACTIVE or IDLE, fifo_empty_i=0 and occ+infl<3; no combinational path from m_ready_i.
REQ-014 infl SHALL be set on the edge where fifo_rd_en_o=1, cleared otherwise; when infl=1, fifo_rdata_i SHALL be written to the buffer tail on that edge.
REQ-015 m_valid_o SHALL equal (occ!=0) in IDLE/ACTIVE, 0 in FLUSH; a transfer occurs when m_valid_o&m_ready_i, popping the head on that edge.
REQ-016 Simultaneous push and pop SHALL leave occ unchanged and preserve order; FIFO-to-stream latency SHALL be 2 cycles (rd_en at cycle N, m_valid_o at N+2).
REQ-017 Sustained throughput SHALL be one word per cycle when fifo_empty_i=0 and m_ready_i=1.
REQ-018 m_data_o SHALL hold stable while m_valid_o=1 and m_ready_i=0.
REQ-019 FSM states: IDLE (occ=0, infl=0), ACTIVE (occ+infl>0), FLUSH.
REQ-020 IDLE->ACTIVE on read issue; ACTIVE->IDLE when occ+infl becomes 0; any state->FLUSH on flush_i=1.
REQ-021 Entering FLUSH SHALL zero occ on that edge; a word arriving with infl=1 during FLUSH SHALL be discarded; no reads issued in FLUSH.
REQ-022 FLUSH->IDLE on the first edge with infl=0 and flush_i=0.
REQ-023 drop_o SHALL pulse for one cycle on the edge after flush_i is sampled with occ+infl>0; otherwise 0.
REQ-024 flush_i has priority over push and pop in the same cycle; no transfer occurs on that edge.

Reset
REQ-025 While rst_i=0 on an edge: state=IDLE, occ=0, infl=0, m_data_o=0, drop_o=0, and any in-flight word SHALL be discarded.
REQ-026 fifo_rd_en_o and m_valid_o SHALL be 0 whenever rst_i=0, including mid-operation.

Configuration
REQ-027 Macro FIFO_RD_CNT_EN defined: an extra output count_o (16 bits) SHALL count transfers, reset to 0, wrapping 0xFFFF->0, unaffected by flush.
REQ-028 Macro FIFO_RD_CNT_EN undefined: count_o port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-029 Package fifo_rd_pkg SHALL hold the state-encoding typedef (IDLE, ACTIVE, FLUSH), BUF_DEPTH=3 and the count width 16.
REQ-030 The buffer SHALL be the sub-module fifo_rd_skid (push, pop, clear, data, occ); FSM and read issue live in fifo_rd_ctrl.

Verification
REQ-031 Reset then FIFO preloaded 0x11,0x22,0x33, m_ready_i=1 -> rd_en cycles 1-3, m_valid_o cycles 3-5 with 0x11,0x22,0x33, then IDLE.
REQ-032 m_ready_i=0 with 5 words queued -> exactly 3 reads issued, occ=3, rd_en held 0; m_ready_i=1 -> words emerge in order, no loss or duplication.
REQ-033 Continuous 20 words, m_ready_i=1 -> one transfer per cycle after 2-cycle latency; count_o=20 with FIFO_RD_CNT_EN.
REQ-034 flush_i one cycle with occ=2, infl=1 -> occ=0, arriving word dropped, drop_o one pulse, m_valid_o=0 until new data read after return to IDLE.
REQ-035 rst_i=0 mid-stream with occ=2 -> next cycle m_valid_o=0, fifo_rd_en_o=0, m_data_o=0; late fifo_rdata_i ignored.
REQ-036 count_o at 0xFFFF plus one transfer -> 0x0000.
